// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with character-cell counters
// Every output is registered from the position about to be presented, so the decode adds no extra pipeline stage.
module video_timing_gen #(
  parameter int   H_ACTIVE = 720,
  parameter int   H_FP     = 10,
  parameter int   H_SYNC   = 135,
  parameter int   H_BP     = 17,
  parameter int   V_ACTIVE = 350,
  parameter int   V_FP     = 2,
  parameter int   V_SYNC   = 16,
  parameter int   V_BP     = 1,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b0,
  parameter int   CHAR_W   = 9,
  parameter int   CHAR_H   = 14,
  parameter int   XW       = 10,
  parameter int   YW       = 9
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          enable,
  output logic [XW-1:0] xpix,
  output logic [YW-1:0] ypix,
  output logic [6:0]    col,
  output logic [5:0]    row,
  output logic [3:0]    glyph_x,
  output logic [3:0]    glyph_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          cursor_blink,
  output logic          char_blink
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] HA     = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HLAST  = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VA     = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VLAST  = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]    GX_MAX = 4'(CHAR_W - 1);
  localparam logic [3:0]    GY_MAX = 4'(CHAR_H - 1);

  logic          started;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic          wrap_frame;
  logic [4:0]    frame_cnt;

  logic          n_hs, n_vs, n_en;
  logic [XW-1:0] n_xpix;
  logic [YW-1:0] n_ypix;
  logic [6:0]    n_col;
  logic [5:0]    n_row;
  logic [3:0]    n_gx, n_gy;

  // Position advance; the first enabled edge after reset lands on (0,0) rather than (1,0).
  always_comb begin
    nx = x;
    ny = y;
    wrap_frame = 1'b0;
    if (!started) begin
      nx = '0;
      ny = '0;
    end else if (x == HLAST) begin
      nx = '0;
      if (y == VLAST) begin
        ny = '0;
        wrap_frame = 1'b1;
      end else begin
        ny = y + 1'b1;
      end
    end else begin
      nx = x + 1'b1;
    end
  end

  // Cell counters step incrementally from the presented values; outside active they simply hold.
  always_comb begin
    n_gx  = glyph_x;
    n_col = col;
    if (nx == '0) begin
      n_gx  = '0;
      n_col = '0;
    end else if (nx < HA) begin
      if (glyph_x == GX_MAX) begin
        n_gx  = '0;
        n_col = col + 7'd1;
      end else begin
        n_gx = glyph_x + 4'd1;
      end
    end

    n_gy  = glyph_y;
    n_row = row;
    if (nx == '0) begin
      if (ny == '0) begin
        n_gy  = '0;
        n_row = '0;
      end else if (ny < VA) begin
        if (glyph_y == GY_MAX) begin
          n_gy  = '0;
          n_row = row + 6'd1;
        end else begin
          n_gy = glyph_y + 4'd1;
        end
      end
    end
  end

  always_comb begin
    n_en   = (nx < HA) && (ny < VA);
    n_hs   = (nx >= HS_BEG && nx < HS_END) ? HS_POL : ~HS_POL;
    n_vs   = (ny >= VS_BEG && ny < VS_END) ? VS_POL : ~VS_POL;
    n_xpix = (nx < HA) ? nx : HA - 1'b1;
    n_ypix = (ny < VA) ? ny : VA - 1'b1;
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      started     <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_cnt   <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      enable      <= 1'b0;
      xpix        <= '0;
      ypix        <= '0;
      col         <= '0;
      row         <= '0;
      glyph_x     <= '0;
      glyph_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        started     <= 1'b1;
        x           <= nx;
        y           <= ny;
        if (wrap_frame)
          frame_cnt <= frame_cnt + 5'd1;
        hs          <= n_hs;
        vs          <= n_vs;
        enable      <= n_en;
        xpix        <= n_xpix;
        ypix        <= n_ypix;
        col         <= n_col;
        row         <= n_row;
        glyph_x     <= n_gx;
        glyph_y     <= n_gy;
        line_start  <= (nx == '0);
        frame_start <= (nx == '0) && (ny == '0);
      end
    end
  end

  assign cursor_blink = frame_cnt[3];
  assign char_blink   = frame_cnt[4];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench: default, 640x480 and a tiny raster instance
module tb_video_timing_gen;

  logic pixclk = 1'b0;
  logic rst, ce;
  always #5 pixclk = ~pixclk;

  logic       hs_m, vs_m, en_m, ls_m, fs_m, cb_m, chb_m;
  logic [9:0] xpix_m;
  logic [8:0] ypix_m;
  logic [6:0] col_m;
  logic [5:0] row_m;
  logic [3:0] gx_m, gy_m;

  logic       hs_v, vs_v, en_v, ls_v, fs_v, cb_v, chb_v;
  logic [9:0] xpix_v;
  logic [9:0] ypix_v;
  logic [6:0] col_v;
  logic [5:0] row_v;
  logic [3:0] gx_v, gy_v;

  logic       hs_s, vs_s, en_s, ls_s, fs_s, cb_s, chb_s;
  logic [3:0] xpix_s, ypix_s;
  logic [6:0] col_s;
  logic [5:0] row_s;
  logic [3:0] gx_s, gy_s;

  video_timing_gen dut_m (
    .pixclk(pixclk), .rst(rst), .ce(ce), .hs(hs_m), .vs(vs_m), .enable(en_m),
    .xpix(xpix_m), .ypix(ypix_m), .col(col_m), .row(row_m), .glyph_x(gx_m), .glyph_y(gy_m),
    .line_start(ls_m), .frame_start(fs_m), .cursor_blink(cb_m), .char_blink(chb_m)
  );

  video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHAR_W(8), .CHAR_H(16), .XW(10), .YW(10)
  ) dut_v (
    .pixclk(pixclk), .rst(rst), .ce(ce), .hs(hs_v), .vs(vs_v), .enable(en_v),
    .xpix(xpix_v), .ypix(ypix_v), .col(col_v), .row(row_v), .glyph_x(gx_v), .glyph_y(gy_v),
    .line_start(ls_v), .frame_start(fs_v), .cursor_blink(cb_v), .char_blink(chb_v)
  );

  // 15 x 10 raster (150 pixels per frame) so many frames fit in a short run.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CHAR_W(3), .CHAR_H(4), .XW(4), .YW(4)
  ) dut_s (
    .pixclk(pixclk), .rst(rst), .ce(ce), .hs(hs_s), .vs(vs_s), .enable(en_s),
    .xpix(xpix_s), .ypix(ypix_s), .col(col_s), .row(row_s), .glyph_x(gx_s), .glyph_y(gy_s),
    .line_start(ls_s), .frame_start(fs_s), .cursor_blink(cb_s), .char_blink(chb_s)
  );

  typedef struct {
    int cyc; int en; int hs; int xpix; int ypix; int col; int gx; int row; int gy; int ls; int fs;
  } vec_t;

  vec_t tbl[16];
  int n_cmp = 0;
  int n_err = 0;
  int cur_k = 0;

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", nm, cur_k, act, exp);
    end
  endtask

  task automatic chk_sm(int p, bit c);
    int fr, r, x, y, xp, yp;
    fr = (p / 150) % 32;
    r  = p % 150;
    y  = r / 15;
    x  = r % 15;
    xp = (x < 8) ? x : 7;
    yp = (y < 6) ? y : 5;
    chk("sm_en",    en_s,   (x < 8 && y < 6) ? 1 : 0);
    chk("sm_hs",    hs_s,   (x >= 10 && x < 13) ? 1 : 0);
    chk("sm_vs",    vs_s,   (y >= 7 && y < 9) ? 0 : 1);
    chk("sm_xpix",  xpix_s, xp);
    chk("sm_ypix",  ypix_s, yp);
    chk("sm_col",   col_s,  xp / 3);
    chk("sm_gx",    gx_s,   xp % 3);
    chk("sm_row",   row_s,  yp / 4);
    chk("sm_gy",    gy_s,   yp % 4);
    chk("sm_ls",    ls_s,   (c && x == 0) ? 1 : 0);
    chk("sm_fs",    fs_s,   (c && x == 0 && y == 0) ? 1 : 0);
    chk("sm_cblk",  cb_s,   (fr >> 3) & 1);
    chk("sm_chblk", chb_s,  (fr >> 4) & 1);
  endtask

  task automatic chk_rst_s();
    chk("rst_hs_s", hs_s, 0);
    chk("rst_vs_s", vs_s, 1);
    chk("rst_en_s", en_s, 0);
    chk("rst_xy_s", {xpix_s, ypix_s}, 0);
    chk("rst_cell_s", {col_s, row_s, gx_s, gy_s}, 0);
    chk("rst_pulse_s", {ls_s, fs_s}, 0);
    chk("rst_blink_s", {cb_s, chb_s}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int ti;
    rst = 1'b1;
    ce  = 1'b0;
    //         cyc    en hs xpix ypix col gx row gy ls fs
    tbl[0]  = '{0,     1, 0, 0,   0,   0,  0, 0,  0, 1, 1};
    tbl[1]  = '{8,     1, 0, 8,   0,   0,  8, 0,  0, 0, 0};
    tbl[2]  = '{9,     1, 0, 9,   0,   1,  0, 0,  0, 0, 0};
    tbl[3]  = '{719,   1, 0, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[4]  = '{720,   0, 0, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[5]  = '{729,   0, 0, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[6]  = '{730,   0, 1, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[7]  = '{800,   0, 1, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[8]  = '{864,   0, 1, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[9]  = '{865,   0, 0, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[10] = '{881,   0, 0, 719, 0,   79, 8, 0,  0, 0, 0};
    tbl[11] = '{882,   1, 0, 0,   1,   0,  0, 0,  1, 1, 0};
    tbl[12] = '{891,   1, 0, 9,   1,   1,  0, 0,  1, 0, 0};
    tbl[13] = '{11466, 1, 0, 0,   13,  0,  0, 0, 13, 1, 0};
    tbl[14] = '{12348, 1, 0, 0,   14,  0,  0, 1,  0, 1, 0};
    tbl[15] = '{13067, 1, 0, 719, 14,  79, 8, 1,  0, 0, 0};

    do_reset();
    chk("rst_hs_m", hs_m, 0);
    chk("rst_vs_m", vs_m, 1);
    chk("rst_en_m", en_m, 0);
    chk("rst_xy_m", {xpix_m, ypix_m}, 0);
    chk("rst_pulse_m", {ls_m, fs_m}, 0);
    chk("rst_hs_v", hs_v, 1);
    chk("rst_vs_v", vs_v, 1);
    chk_rst_s();

    // Free-running ce=1: table for the default raster, formulas for the others.
    ti = 0;
    for (int k = 0; k < 13100; k++) begin
      int xm, xv, yv, xpv;
      cur_k = k;
      ce = 1'b1;
      step();
      xm = k % 882;
      xv = k % 800;
      yv = k / 800;
      xpv = (xv < 640) ? xv : 639;
      if (ti < 16 && tbl[ti].cyc == k) begin
        chk("t_en",   en_m,   tbl[ti].en);
        chk("t_hs",   hs_m,   tbl[ti].hs);
        chk("t_xpix", xpix_m, tbl[ti].xpix);
        chk("t_ypix", ypix_m, tbl[ti].ypix);
        chk("t_col",  col_m,  tbl[ti].col);
        chk("t_gx",   gx_m,   tbl[ti].gx);
        chk("t_row",  row_m,  tbl[ti].row);
        chk("t_gy",   gy_m,   tbl[ti].gy);
        chk("t_ls",   ls_m,   tbl[ti].ls);
        chk("t_fs",   fs_m,   tbl[ti].fs);
        ti++;
      end
      chk("m_hs", hs_m, (xm >= 730 && xm < 865) ? 1 : 0);
      chk("m_en", en_m, (xm < 720) ? 1 : 0);
      chk("m_vs", vs_m, 1);
      chk("m_ls", ls_m, (xm == 0) ? 1 : 0);
      chk("m_fs", fs_m, (k == 0) ? 1 : 0);
      chk("m_blink", {cb_m, chb_m}, 0);
      chk("v_hs", hs_v, (xv >= 656 && xv < 752) ? 0 : 1);
      chk("v_vs", vs_v, 1);
      chk("v_en", en_v, (xv < 640) ? 1 : 0);
      chk("v_ls", ls_v, (xv == 0) ? 1 : 0);
      chk("v_fs", fs_v, (k == 0) ? 1 : 0);
      chk("v_xpix", xpix_v, xpv);
      chk("v_ypix", ypix_v, yv);
      chk("v_cell", {col_v, gx_v}, {7'(xpv / 8), 4'(xpv % 8)});
      chk("v_rowc", {row_v, gy_v}, {6'(yv / 16), 4'(yv % 16)});
      chk("v_blink", {cb_v, chb_v}, 0);
      chk_sm(k, 1'b1);
    end
    chk("tbl_done", ti, 16);

    // ce pattern 1,0: every state holds on ce=0 cycles and pulses drop to 0.
    do_reset();
    for (int k = 0; k < 1800; k++) begin
      bit c;
      cur_k = k;
      c  = (k % 2 == 0);
      ce = c;
      step();
      chk_sm(k / 2, c);
      chk("m_ls_ce", ls_m, (c && ((k / 2) % 882 == 0)) ? 1 : 0);
      chk("m_fs_ce", fs_m, (c && k == 0) ? 1 : 0);
    end

    // Reset landing inside hsync of frame 9 (cursor_blink already high).
    do_reset();
    for (int k = 0; k <= 1406; k++) begin
      cur_k = k;
      ce = 1'b1;
      step();
    end
    chk_sm(1406, 1'b1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cur_k = k;
      step();
      chk_rst_s();
    end
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cur_k = k;
      step();
      chk_sm(k, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
